mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage load/store unit. Sits directly downstream of the EX/MEM pipeline register and consumes its address, store data and data-memory controls. It drives a word-addressed request/ready data bus, splits misaligned halfword/word accesses into two bus transactions, and formats load data (sign/zero extension). It raises `mem_stall`, which the pipeline uses to hold `pip_en` low until the access completes.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum wait cycles per bus transaction before abort (1..255).

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `alu_out`  in  32  byte address of the access.
- `rs2`  in  32  store data, LSB-justified.
- `DMread`  in  1  load request.
- `DMwriteEn`  in  1  store request. Wins over `DMread` if both are set.
- `DM_ctrl`  in  3  bits [1:0]: 00 byte, 01 half, 1x word. Bit [2]: unsigned load (ignored for stores and word loads).
- `mem_stall`  out  1  combinational. Hold the pipeline (`pip_en = ~mem_stall`).
- `load_data`  out  32  formatted load result.
- `load_valid`  out  1  one-cycle strobe; `load_data` is valid.
- `bus_err`  out  1  one-cycle strobe; transaction timed out.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word-aligned address (bits [1:0] = 0).
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  write data, lane-aligned.
- `bus_ready`  in  1  completes the current transaction; `bus_rdata` is valid in the same cycle.
- `bus_rdata`  in  32  read data.

## Operation
- `op = DMread | DMwriteEn`; `off = alu_out[1:0]`.
- `split = (half && off==3) || (word && off!=0)`. Byte accesses never split.
- State machine: IDLE, ACC0, ACC1, DONE.
  - IDLE: if `op`, latch address, data, ctrl and we; go to ACC0.
  - ACC0: `bus_req=1`, `bus_addr = {addr[31:2],2'b00}`. On `bus_ready`: if `split`, go to ACC1; else go to DONE.
  - ACC1: `bus_req=1`, `bus_addr` = first address + 4. On `bus_ready`, go to DONE.
  - DONE: `load_valid=1` if the op was a load. Always return to IDLE.
- Store data and enables:
  - `w64 = {32'b0, data} << (8*off)`. ACC0 drives `w64[31:0]`; ACC1 drives `w64[63:32]`.
  - `mask64 = {60'b0, m} << off`, where m = 0001 (byte), 0011 (half), 1111 (word). `bus_be` = `mask64[3:0]` in ACC0 and `mask64[7:4]` in ACC1.
  - For reads, `bus_be` uses the same masks.
- Load formatting:
  - ACC0 rdata is captured into r64[31:0]; ACC1 rdata into r64[63:32].
  - `v = r64 >> (8*off)`; truncate to the access size.
  - Sign-extend unless `DM_ctrl[2]`=1. Word loads are never extended.
- `mem_stall` = `(state==IDLE && op) || state==ACC0 || state==ACC1`. It is low in DONE, so the EX/MEM register advances at the end of DONE.
- Timeout:
  - An 8-bit wait counter clears on each transaction entry and increments every ACC cycle without `bus_ready`.
  - When the counter reaches `TIMEOUT`, drop `bus_req` and go to DONE with `bus_err=1`, `load_valid=0`, `load_data=0`.
  - A split access aborts entirely; its second half is not issued.

## Timing
- Reset (rst_n=0 at an edge): state IDLE. `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `load_data`, `load_valid`, `bus_err` all go to 0.
- `mem_stall` is forced to 0 while `rst_n`=0.
- Reset mid-access: the access is abandoned. `bus_req` goes low at that edge, and no `load_valid` or `bus_err` is issued.
- Bus outputs are registered and stable while `bus_req`=1 and `bus_ready`=0. They change only after a `bus_ready` edge.
- Aligned access, `bus_ready` in the first ACC0 cycle: stall lasts 2 cycles (IDLE, ACC0), then DONE. Total 3 cycles per memory op.
- A split access adds one or more cycles in ACC1.
- `load_data` holds its value until the next DONE or reset.
- Back-to-back memory ops: after DONE, IDLE samples the next op, so consecutive ops issue with no gap beyond the IDLE cycle.
- Non-memory ops in IDLE: `mem_stall`=0, no bus activity.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `DMread`=1 → all outputs 0, `mem_stall`=0. After release, the first access starts from IDLE.
- Aligned SW of 0xDEADBEEF to 0x100, ready immediately → one transaction: addr 0x100, be 1111, wdata 0xDEADBEEF. `mem_stall` high exactly 2 cycles.
- LB at 0x103 with rdata 0x80xxxxxx → `load_data`=0xFFFFFF80. LBU at the same address → 0x00000080. `load_valid` is a 1-cycle pulse.
- Misaligned LW at 0x202, rdata 0x11223344 at 0x200 then 0x55667788 at 0x204 → two transactions, addr 0x200 then 0x204, be 1100 then 0011; `load_data`=0x77881122.
- Misaligned SH of 0xABCD to 0x3 → ACC0: addr 0x0, be 1000, wdata 0xCD000000. ACC1: addr 0x4, be 0001, wdata 0x000000AB.
- Timeout: `TIMEOUT`=4, `bus_ready` never asserted on an LW → `bus_req` drops after 4 wait cycles; `bus_err` pulses once; `load_valid`=0; `mem_stall` falls. A second reset asserted mid-ACC0 aborts cleanly.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Word-addressed request/ready data bus between the memory stage and data memory.
// The memory stage is the master; the memory (or its bench model) is the slave.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues word bus transactions (two for misaligned
// accesses that cross a word), formats load data and stalls the pipeline meanwhile.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_out,
    input  logic [31:0] rs2,
    input  logic        DMread,
    input  logic        DMwriteEn,
    input  logic [2:0]  DM_ctrl,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_err,
    mem_access_unit_if.master bus
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    // Wait count at which the current transaction is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    function automatic logic is_split(input logic [2:0] ctrl, input logic [1:0] off);
        if (ctrl[1]) return off != 2'd0;
        return ctrl[0] && (off == 2'd3);
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] ctrl, input logic [1:0] off,
                                           input logic hi);
        logic [7:0] m;
        m = ctrl[1] ? 8'b0000_1111 : (ctrl[0] ? 8'b0000_0011 : 8'b0000_0001);
        m = m << off;
        return hi ? m[7:4] : m[3:0];
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [31:0] d, input logic [1:0] off,
                                               input logic hi);
        logic [63:0] w;
        w = {32'b0, d} << {off, 3'b000};
        return hi ? w[63:32] : w[31:0];
    endfunction

    // Shift the two captured words down to the access and extend to 32 bits.
    function automatic logic [31:0] fmt_load(input logic [63:0] r64, input logic [1:0] off,
                                             input logic [2:0] ctrl);
        logic [31:0] v;
        v = 32'(r64 >> {off, 3'b000});
        if (ctrl[1]) return v;
        if (ctrl[0]) return {{16{v[15] & ~ctrl[2]}}, v[15:0]};
        return {{24{v[7] & ~ctrl[2]}}, v[7:0]};
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] rlo_q, rlo_d;
    logic        we_q, we_d;
    logic [7:0]  wait_q, wait_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        bus_err_q, bus_err_d;

    logic        op;
    logic        access_split;
    logic [63:0] r64;

    assign op           = DMread | DMwriteEn;
    assign access_split = is_split(ctrl_q, off_q);

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        data_d       = data_q;
        ctrl_d       = ctrl_q;
        rlo_d        = rlo_q;
        we_d         = we_q;
        wait_d       = wait_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_err_d    = 1'b0;
        r64          = '0;

        case (state_q)
            IDLE: begin
                if (op) begin
                    off_d       = alu_out[1:0];
                    data_d      = rs2;
                    ctrl_d      = DM_ctrl;
                    we_d        = DMwriteEn;
                    wait_d      = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = DMwriteEn;
                    bus_addr_d  = {alu_out[31:2], 2'b00};
                    bus_be_d    = lane_be(DM_ctrl, alu_out[1:0], 1'b0);
                    bus_wdata_d = lane_wdata(rs2, alu_out[1:0], 1'b0);
                    state_d     = ACC0;
                end
            end
            ACC0, ACC1: begin
                r64 = (state_q == ACC1) ? {bus.bus_rdata, rlo_q} : {32'b0, bus.bus_rdata};
                if (bus.bus_ready) begin
                    wait_d = '0;
                    if ((state_q == ACC0) && access_split) begin
                        state_d     = ACC1;
                        rlo_d       = bus.bus_rdata;
                        bus_addr_d  = bus_addr_q + 32'd4;
                        bus_be_d    = lane_be(ctrl_q, off_q, 1'b1);
                        bus_wdata_d = lane_wdata(data_q, off_q, 1'b1);
                    end else begin
                        state_d   = DONE;
                        bus_req_d = 1'b0;
                        if (!we_q) begin
                            load_valid_d = 1'b1;
                            load_data_d  = fmt_load(r64, off_q, ctrl_q);
                        end
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // Abort the whole access; a pending second half is never issued.
                    state_d     = DONE;
                    bus_req_d   = 1'b0;
                    bus_err_d   = 1'b1;
                    load_data_d = '0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            wait_q       <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            wait_q       <= wait_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Access operands are only consumed in ACC states, which always follow a fresh latch.
    always_ff @(posedge clk) begin
        off_q  <= off_d;
        data_q <= data_d;
        ctrl_q <= ctrl_d;
        rlo_q  <= rlo_d;
    end

    assign mem_stall = rst_n && (((state_q == IDLE) && op) || (state_q == ACC0) || (state_q == ACC1));

    assign load_data     = load_data_q;
    assign load_valid    = load_valid_q;
    assign bus_err       = bus_err_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule
